// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master core among three requesters.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to add the ABORT path and m_abort.
//
// state | meaning
// IDLE  | waiting for any req; round-robin winner latched on exit
// GRANT | winner's address/rw/wdata copied to the master command
// START | m_start held until the master reports m_busy
// WAIT  | master busy; waiting for m_done
// DONE  | one-cycle completion pulse to the granted requester
// ABORT | one-cycle watchdog abort (I2C_ARB_TIMEOUT_EN only)
module i2c_req_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [20:0] req_addr,
    input  logic [2:0]  req_rw,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [2:0]  ack_err,
    output logic [7:0]  rdata,
    output logic        interupt,
    output logic        m_start,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_wdata,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_nack,
    input  logic [7:0]  m_rdata,
    output logic        m_abort
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
`ifdef I2C_ARB_TIMEOUT_EN
        ABORT = 3'd5,
`endif
        DONE  = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] last_gnt;
    logic [1:0] win_idx;
    logic       win_vld;
    logic [1:0] c1, c2, c3;

    if (TIMEOUT_CYC < 16'd2) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 2");
    end

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // c1 is the highest-priority candidate, so it is evaluated last
    always_comb begin
        c1 = rr_next(last_gnt);
        c2 = rr_next(c1);
        c3 = rr_next(c2);
        win_idx = 2'd0;
        win_vld = 1'b0;
        if (req[c3]) begin win_idx = c3; win_vld = 1'b1; end
        if (req[c2]) begin win_idx = c2; win_vld = 1'b1; end
        if (req[c1]) begin win_idx = c1; win_vld = 1'b1; end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_hit;
    assign to_hit = (to_cnt == 16'(TIMEOUT_CYC - 16'd1));
`else
    assign m_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_gnt <= 2'd2;
            gnt      <= '0;
            done     <= '0;
            ack_err  <= '0;
            rdata    <= '0;
            interupt <= 1'b0;
            m_start  <= 1'b0;
            m_addr   <= '0;
            m_rw     <= 1'b0;
            m_wdata  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            m_abort  <= 1'b0;
            to_cnt   <= '0;
`endif
        end else begin
            done     <= '0;
            ack_err  <= '0;
            interupt <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            m_abort  <= 1'b0;
            if (state == START || state == WAIT)
                to_cnt <= to_cnt + 16'd1;
`endif
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt      <= 3'b001 << win_idx;
                        last_gnt <= win_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    case (last_gnt)
                        2'd0: begin
                            m_addr  <= req_addr[6:0];
                            m_rw    <= req_rw[0];
                            m_wdata <= req_wdata[7:0];
                        end
                        2'd1: begin
                            m_addr  <= req_addr[13:7];
                            m_rw    <= req_rw[1];
                            m_wdata <= req_wdata[15:8];
                        end
                        default: begin
                            m_addr  <= req_addr[20:14];
                            m_rw    <= req_rw[2];
                            m_wdata <= req_wdata[23:16];
                        end
                    endcase
                    m_start <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    state   <= START;
                end
                START: begin
                    if (m_busy) begin
                        m_start <= 1'b0;
                        state   <= WAIT;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        m_start  <= 1'b0;
                        m_abort  <= 1'b1;
                        done     <= gnt;
                        ack_err  <= gnt;
                        interupt <= 1'b1;
                        rdata    <= '0;
                        state    <= ABORT;
                    end
`endif
                end
                WAIT: begin
                    if (m_done) begin
                        done     <= gnt;
                        ack_err  <= m_nack ? gnt : 3'b000;
                        interupt <= 1'b1;
                        rdata    <= m_rw ? m_rdata : 8'h00;
                        state    <= DONE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        m_abort  <= 1'b1;
                        done     <= gnt;
                        ack_err  <= gnt;
                        interupt <= 1'b1;
                        rdata    <= '0;
                        state    <= ABORT;
                    end
`endif
                end
                DONE: begin
                    gnt   <= '0;
                    rdata <= '0;
                    state <= IDLE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                ABORT: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized transaction-level bench for i2c_req_arbiter with a round-robin reference model.
// Exercises the watchdog path as well when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [20:0] req_addr;
    logic [2:0]  req_rw;
    logic [23:0] req_wdata;
    logic [2:0]  gnt, done, ack_err;
    logic [7:0]  rdata;
    logic        interupt;
    logic        m_start;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_wdata;
    logic        m_busy, m_done, m_nack;
    logic [7:0]  m_rdata;
    logic        m_abort;

    int n_chk  = 0;
    int n_pass = 0;
    int model_last;

    i2c_req_arbiter #(.TIMEOUT_CYC(16'd100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .ack_err(ack_err), .rdata(rdata),
        .interupt(interupt), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
        .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
        .m_rdata(m_rdata), .m_abort(m_abort)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // first requester at or after (last+1) mod 3 that is asking
    function automatic int rr_pick(input logic [2:0] rq, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [2:0] rq, input logic nack, input int bd, input int dd,
                           input logic drop, input logic dir, input logic [6:0] d_addr,
                           input logic d_rw, input logic [7:0] d_wdata, input logic [7:0] d_rdata,
                           output logic [2:0] obs_gnt);
        int w;
        logic [2:0] oh;
        logic [6:0] a;
        logic       r;
        logic [7:0] wd, rd;
        w  = rr_pick(rq, model_last);
        oh = 3'(1 << w);
        req_addr  = 21'($urandom);
        req_rw    = 3'($urandom);
        req_wdata = 24'($urandom);
        a  = dir ? d_addr  : 7'($urandom);
        r  = dir ? d_rw    : 1'($urandom);
        wd = dir ? d_wdata : 8'($urandom);
        rd = dir ? d_rdata : 8'($urandom_range(1, 255));
        req_addr[7*w +: 7]  = a;
        req_rw[w]           = r;
        req_wdata[8*w +: 8] = wd;
        req = rq;
        step();
        obs_gnt = gnt;
        check("gnt_latch", gnt, oh);
        check("m_start_early", m_start, 1'b0);
        step();
        check("m_start", m_start, 1'b1);
        check("m_cmd", {m_addr, m_rw, m_wdata}, {a, r, wd});
        if (drop) req = 3'b000;
        for (int i = 0; i < bd; i++) begin
            m_done = 1'($urandom);
            m_nack = 1'b1;
            step();
            check("m_start_hold", {m_start, done}, {1'b1, 3'b000});
        end
        m_done = 1'b0;
        m_nack = 1'b0;
        m_busy = 1'b1;
        step();
        m_busy = 1'b0;
        check("m_start_clr", m_start, 1'b0);
        for (int i = 0; i < dd; i++) begin
            m_busy = 1'($urandom);
            step();
            check("no_early_done", {done, interupt}, 4'h0);
        end
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_nack  = nack;
        m_rdata = rd;
        step();
        m_done  = 1'b0;
        m_nack  = 1'b0;
        check("done_pulse", {done, ack_err, interupt, gnt, m_abort},
              {oh, nack ? oh : 3'b000, 1'b1, oh, 1'b0});
        check("rdata", rdata, r ? rd : 8'h00);
        step();
        check("back_idle", {done, ack_err, interupt, gnt, rdata}, 18'h0);
        model_last = w;
        req = 3'b000;
    endtask

    logic [2:0] g;
    logic [2:0] fair_exp [4];
    logic       early;

    initial begin
        fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100; fair_exp[3] = 3'b001;
        reset = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
        model_last = 2;
        step(); step();
        check("rst_outs_a", {gnt, done, ack_err, rdata, interupt}, 18'h0);
        check("rst_outs_b", {m_start, m_abort, m_addr, m_rw, m_wdata}, 18'h0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_txn(3'b111, 1'b0, i, i, 1'b0, 1'b0, 7'h0, 1'b0, 8'h0, 8'h0, g);
            check("fair_order", g, fair_exp[i]);
        end

        run_txn(3'b010, 1'b0, 0, 1, 1'b0, 1'b1, 7'h50, 1'b0, 8'hA5, 8'h77, g);
        run_txn(3'b001, 1'b0, 1, 0, 1'b0, 1'b1, 7'h21, 1'b1, 8'h00, 8'h3C, g);
        run_txn(3'b100, 1'b1, 2, 2, 1'b1, 1'b0, 7'h0, 1'b0, 8'h0, 8'h0, g);

        for (int i = 0; i < 30; i++)
            run_txn(3'($urandom_range(1, 7)), 1'($urandom), $urandom_range(0, 4),
                    $urandom_range(0, 4), 1'($urandom), 1'b0, 7'h0, 1'b0, 8'h0, 8'h0, g);

        req = 3'b010; req_addr = 21'h1FFFFF; req_wdata = 24'hFFFFFF; req_rw = 3'b111;
        step(); step();
        m_busy = 1'b1; step(); m_busy = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        check("rst_wait_a", {gnt, done, ack_err, rdata, interupt}, 18'h0);
        check("rst_wait_b", {m_start, m_abort, m_addr, m_rw, m_wdata}, 18'h0);
        m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hEE;
        step();
        check("rst_no_done", {done, interupt}, 4'h0);
        m_done = 1'b0; m_nack = 1'b0;
        req = 3'b000;
        reset = 1'b1;
        model_last = 2;
        step();
        run_txn(3'b111, 1'b0, 0, 0, 1'b0, 1'b0, 7'h0, 1'b0, 8'h0, 8'h0, g);
        check("post_rst_first", g, 3'b001);

`ifdef I2C_ARB_TIMEOUT_EN
        req = 3'b110;
        g = 3'(1 << rr_pick(3'b110, model_last));
        step(); step();
        req = 3'b000;
        early = 1'b0;
        for (int i = 0; i < 99; i++) begin
            step();
            early = early | m_abort | (|done);
        end
        check("abort_early", early, 1'b0);
        step();
        check("abort_pulse", {m_abort, done, ack_err, interupt, rdata}, {1'b1, g, g, 1'b1, 8'h00});
        step();
        check("abort_idle", {m_abort, done, gnt, interupt}, 8'h0);
        model_last = rr_pick(3'b110, model_last);
        run_txn(3'b111, 1'b0, 1, 1, 1'b0, 1'b0, 7'h0, 1'b0, 8'h0, 8'h0, g);
`else
        check("abort_tied", m_abort, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000: cycles allowed from m_start assertion to m_done before abort; legal range 2..65535.
REQ-002 Port clk  in  1  single system clock; all logic on rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Port req  in  3  per-requester transaction request; bit i = requester i.
REQ-005 Port req_addr  in  21  7-bit slave address per requester; requester i = bits [7i+6:7i].
REQ-006 Port req_rw  in  3  per-requester direction: 1 = read, 0 = write.
REQ-007 Port req_wdata  in  24  8-bit write byte per requester; requester i = bits [8i+7:8i].
REQ-008 Port gnt  out  3  one-hot grant, held for the whole transaction.
REQ-009 Port done  out  3  one-cycle completion pulse to the granted requester.
REQ-010 Port ack_err  out  3  NACK/abort flag; pulses with done.
REQ-011 Port rdata  out  8  read byte; valid only in the done cycle.
REQ-012 Port interupt  out  1  one-cycle pulse, coincident with any done bit.
REQ-013 Ports m_start out 1, m_addr out 7, m_rw out 1, m_wdata out 8  command to the I2C master core.
REQ-014 Ports m_busy in 1, m_done in 1, m_nack in 1, m_rdata in 8  status from the master core; m_nack and m_rdata are valid with the m_done pulse.
REQ-015 Port m_abort  out  1  one-cycle pulse that forces the master core back to idle.

Function
REQ-016 FSM states: IDLE, GRANT, START, WAIT, DONE, ABORT.
REQ-017 IDLE: if any req bit is set, go to GRANT; otherwise stay in IDLE.
REQ-018 Arbitration is round-robin.
- The search starts at (last_gnt+1) mod 3.
- The winner is latched into gnt and last_gnt on the IDLE->GRANT edge.
REQ-019 GRANT: latch the winner's address, rw and wdata into m_addr/m_rw/m_wdata, then go to START.
- These outputs stay stable until the next GRANT.
REQ-020 START: hold m_start=1 until the cycle m_busy=1 is sampled, then go to WAIT.
REQ-021 WAIT: on m_done=1, capture m_nack into ack_err[gnt] and m_rdata into rdata, then go to DONE.
REQ-022 DONE: this state lasts exactly one cycle.
- Assert done[gnt], ack_err[gnt] (if NACK) and interupt.
- Clear gnt and go to IDLE.
REQ-023 Minimum latency: req rise to m_start = 2 cycles; m_done to done = 1 cycle.
REQ-024 Requests are sampled only in IDLE.
- If req drops mid-transaction, the transaction still completes and done still pulses.
REQ-025 Simultaneous requests are resolved by the round-robin order, with no starvation.
- Three continuously asserted requests are served 0,1,2,0,... after reset.
REQ-026 m_done outside WAIT, and m_busy outside START, are ignored.
REQ-027 Write transactions return rdata = 8'h00.

Reset
REQ-028 While reset=0, the FSM is forced to IDLE and the following hold asynchronously:
- gnt=0, done=0, ack_err=0, rdata=0, interupt=0.
- m_start=0, m_abort=0, m_addr=0, m_rw=0, m_wdata=0.
- last_gnt=2, so requester 0 wins first.
REQ-029 Reset mid-transaction drops everything with no done pulse; m_abort is not asserted.

Configuration
REQ-030 Macro I2C_ARB_TIMEOUT_EN, when defined, adds the timeout watchdog.
- A 16-bit counter clears on entry to START and increments in START and WAIT.
- At count TIMEOUT_CYC-1, the FSM goes to ABORT.
- ABORT lasts one cycle: m_abort=1, done[gnt]=1, ack_err[gnt]=1, interupt=1, rdata=0, then IDLE.
REQ-031 Without I2C_ARB_TIMEOUT_EN there is no counter and no ABORT state.
- m_abort is tied to 0.
- The FSM waits indefinitely for m_busy/m_done.

Verification
REQ-032 Single write: req=3'b010, addr 7'h50, wdata 8'hA5, master acks.
- Required: gnt=3'b010; m_start 2 cycles after req; m_addr=7'h50, m_wdata=8'hA5; done[1] 1 cycle after m_done; ack_err=0.
REQ-033 Read: req0 read, m_rdata=8'h3C.
- Required: rdata=8'h3C and done[0] in the same cycle.
REQ-034 Fairness: req=3'b111 held continuously.
- Required: grants in order 001,010,100,001; each done pulse precedes the next gnt.
REQ-035 NACK: m_nack=1 with m_done.
- Required: ack_err[g]=1 and done[g]=1 in the same cycle; interupt pulses.
REQ-036 Timeout (macro defined, TIMEOUT_CYC=100): m_busy never asserts.
- Required: m_abort, done and ack_err all pulse 100 cycles after START entry.
REQ-037 Reset mid-WAIT: reset=0.
- Required: all outputs 0 immediately; no done pulse; after release, req0 is granted first.
